// File: rtl/fetch_unit.sv
// Instruction fetch stage: keeps the fetch PC, issues one word request at a
// time and fills the IF/ID register. A fetched word can be parked in a hold
// buffer while the pipeline stalls. A redirect that arrives while a request is
// outstanding waits for that old request to complete and throws its data away.
//
// Memory handshake: imem_req is high in S_REQ and S_DRAIN and imem_addr is
// held constant until a clock edge samples imem_req=1 and imem_ack=1. That edge
// completes the request, and imem_rdata is taken on the same edge. An ack may
// come in the first cycle of a request. imem_ack is ignored while imem_req=0.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;
  logic        hold_valid_q, hold_valid_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] seq_addr;

  // Redirect target: a jump has priority over a branch, and the target is
  // forced to word alignment.
  always_comb begin
    redirect = br_taken | jmp;
    target   = (jmp ? jmp_target : br_target) & 32'hFFFF_FFFC;
    seq_addr = req_addr_q + 32'd4;
  end

  // Next-state and datapath updates. Every register holds its value unless a
  // case below changes it.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    hold_valid_d = hold_valid_q;
    case (state_q)
      S_REQ: begin
        if (redirect) begin
          // A flush takes priority over stall. If the word returns in this
          // same cycle it is dropped and the new target is requested at once.
          pc_d         = target;
          valid_d      = 1'b0;
          hold_valid_d = 1'b0;
          if (imem_ack) req_addr_d = target;
          else          state_d    = S_DRAIN;
        end else if (imem_ack) begin
          pc_d = seq_addr;
          if (!stall) begin
            instr_d    = imem_rdata;
            pc4_d      = seq_addr;
            valid_d    = 1'b1;
            req_addr_d = seq_addr;
          end else begin
            hold_instr_d = imem_rdata;
            hold_pc4_d   = seq_addr;
            hold_valid_d = 1'b1;
            state_d      = S_HOLD;
          end
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d         = target;
          req_addr_d   = target;
          valid_d      = 1'b0;
          hold_valid_d = 1'b0;
          state_d      = S_REQ;
        end else if (!stall) begin
          // The buffer is emptied as it is used, so a parked word reaches
          // IF/ID only once.
          instr_d      = hold_instr_q;
          pc4_d        = hold_pc4_q;
          valid_d      = hold_valid_q;
          hold_valid_d = 1'b0;
          req_addr_d   = pc_q;
          state_d      = S_REQ;
        end
      end
      S_DRAIN: begin
        valid_d = 1'b0;
        if (redirect) begin
          pc_d         = target;
          hold_valid_d = 1'b0;
        end
        if (imem_ack) begin
          req_addr_d = redirect ? target : pc_q;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // State and datapath registers. Reset is asynchronous and active low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      instr_q      <= 32'd0;
      pc4_q        <= 32'd0;
      valid_q      <= 1'b0;
      hold_instr_q <= 32'd0;
      hold_pc4_q   <= 32'd0;
      hold_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  // Output mapping. The state is also exposed for debug visibility.
  always_comb begin
    imem_req    = (state_q != S_HOLD);
    imem_addr   = req_addr_q;
    pc          = pc_q;
    if_id_instr = instr_q;
    if_id_pc4   = pc4_q;
    if_id_valid = valid_q;
    fsm_state   = state_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit. It drives cycle-by-cycle vector tables that hold the
// inputs and the expected outputs after each clock edge. A scoreboard queue
// confirms that each instruction reaches IF/ID exactly once.
module tb_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_A5A5;
  localparam logic [1:0] ST_REQ = 2'd0, ST_HOLD = 2'd1, ST_DRAIN = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // primary DUT (RESET_PC = 0)
  logic        stall, br_taken, jmp, imem_ack, imem_req, if_id_valid;
  logic [31:0] br_target, jmp_target, imem_addr, imem_rdata, pc, if_id_instr, if_id_pc4;
  logic [1:0]  fsm_state;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .jmp_target(jmp_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .pc(pc), .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .fsm_state(fsm_state)
  );

  // second DUT: reset PC at the top of the address space, zero-wait memory
  logic        stall2, br2, jmp2, ack2, req2, valid2;
  logic [31:0] brt2, jt2, addr2, rdata2, pc2, instr2, pc4_2;
  logic [1:0]  st2;
  assign rdata2 = addr2 ^ K;

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall(stall2), .br_taken(br2), .br_target(brt2),
    .jmp(jmp2), .jmp_target(jt2), .imem_req(req2), .imem_addr(addr2),
    .imem_rdata(rdata2), .imem_ack(ack2), .pc(pc2), .if_id_instr(instr2),
    .if_id_pc4(pc4_2), .if_id_valid(valid2), .fsm_state(st2)
  );

  initial begin
    stall2 = 1'b0; br2 = 1'b0; jmp2 = 1'b0; ack2 = 1'b1; brt2 = '0; jt2 = '0;
  end

  // vector table
  typedef struct {
    logic        stall, ack, br;
    logic [31:0] brt;
    logic        jmp;
    logic [31:0] jt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc4;
    logic [31:0] e_pc;
    logic [1:0]  e_st;
  } vec_t;

  vec_t tbl[$];
  logic [63:0] exp_q[$];   // {pc4, instr}
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic s, input logic a, input logic b, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt_, input logic er,
                              input logic [31:0] ea, input logic ev, input logic [31:0] ep4,
                              input logic [31:0] epc, input logic [1:0] est);
    vec_t v;
    v.stall = s; v.ack = a; v.br = b; v.brt = bt; v.jmp = j; v.jt = jt_;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc4 = ep4; v.e_pc = epc; v.e_st = est;
    tbl.push_back(v);
  endfunction

  // driver tasks
  task automatic drive_idle;
    stall = 1'b0; br_taken = 1'b0; jmp = 1'b0; imem_ack = 1'b0;
    br_target = '0; jmp_target = '0; imem_rdata = $urandom;
  endtask

  task automatic do_reset;
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {63'd0, if_id_valid}, 64'd0);
    chk("rst_instr", {32'd0, if_id_instr}, 64'd0);
    chk("rst_pc4", {32'd0, if_id_pc4}, 64'd0);
    chk("rst_pc", {32'd0, pc}, 64'd0);
    chk("rst_addr", {32'd0, imem_addr}, 64'd0);
    chk("rst_req", {63'd0, imem_req}, 64'd1);
    chk("rst_state", {62'd0, fsm_state}, {62'd0, ST_REQ});
    chk("rst2_pc", {32'd0, pc2}, {32'd0, 32'hFFFF_FFFC});
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // first cycle after release: still requesting the reset PC
    chk("post_rst_req", {63'd0, imem_req}, 64'd1);
    chk("post_rst_addr", {32'd0, imem_addr}, 64'd0);
    // zero-wait fetch at 0xFFFF_FFFC wraps the +4 to 0
    chk("wrap_pc4", {32'd0, pc4_2}, 64'd0);
    chk("wrap_valid", {63'd0, valid2}, 64'd1);
    chk("wrap_instr", {32'd0, instr2}, {32'd0, 32'hFFFF_FFFC ^ K});
    chk("wrap_addr", {32'd0, addr2}, 64'd0);
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      @(negedge clk);
      stall = v.stall; imem_ack = v.ack; br_taken = v.br; br_target = v.brt;
      jmp = v.jmp; jmp_target = v.jt;
      imem_rdata = v.ack ? (imem_addr ^ K) : $urandom;
      if (!v.stall && v.e_valid) exp_q.push_back({v.e_pc4, (v.e_pc4 - 32'd4) ^ K});
      @(posedge clk);
      #1;
      chk($sformatf("%s[%0d].req", name, i), {63'd0, imem_req}, {63'd0, v.e_req});
      chk($sformatf("%s[%0d].addr", name, i), {32'd0, imem_addr}, {32'd0, v.e_addr});
      chk($sformatf("%s[%0d].valid", name, i), {63'd0, if_id_valid}, {63'd0, v.e_valid});
      chk($sformatf("%s[%0d].pc", name, i), {32'd0, pc}, {32'd0, v.e_pc});
      chk($sformatf("%s[%0d].state", name, i), {62'd0, fsm_state}, {62'd0, v.e_st});
      if (v.e_valid)
        chk($sformatf("%s[%0d].pc4", name, i), {32'd0, if_id_pc4}, {32'd0, v.e_pc4});
      // scoreboard: a new delivery happens on any non-stalled edge leaving valid=1
      if (if_id_valid && !v.stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL %s[%0d].sb_unexpected: got pc4 %h expected no delivery", name, i, if_id_pc4);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          chk($sformatf("%s[%0d].sb", name, i), {if_id_pc4, if_id_instr}, e);
        end
      end
    end
    chk($sformatf("%s.sb_left", name), 64'(exp_q.size()), 64'd0);
    tbl.delete();
    exp_q.delete();
  endtask

  // test sequence
  initial begin
    drive_idle();

    // back-to-back zero-wait fetches
    do_reset();
    add(0,1,0,0,0,0, 1,32'h4,1,32'h4,32'h4,ST_REQ);
    add(0,1,0,0,0,0, 1,32'h8,1,32'h8,32'h8,ST_REQ);
    add(0,1,0,0,0,0, 1,32'hC,1,32'hC,32'hC,ST_REQ);
    run_table("seq");

    // stall for three cycles beginning with the ack at 0x8
    do_reset();
    add(0,1,0,0,0,0, 1,32'h4,1,32'h4,32'h4,ST_REQ);
    add(0,1,0,0,0,0, 1,32'h8,1,32'h8,32'h8,ST_REQ);
    add(1,1,0,0,0,0, 0,32'h8,1,32'h8,32'hC,ST_HOLD);
    add(1,0,0,0,0,0, 0,32'h8,1,32'h8,32'hC,ST_HOLD);
    add(1,0,0,0,0,0, 0,32'h8,1,32'h8,32'hC,ST_HOLD);
    add(0,0,0,0,0,0, 1,32'hC,1,32'hC,32'hC,ST_REQ);
    add(0,0,0,0,0,0, 1,32'hC,0,32'h0,32'hC,ST_REQ);
    add(0,1,0,0,0,0, 1,32'h10,1,32'h10,32'h10,ST_REQ);
    run_table("hold");

    // ack delayed two cycles at 0x4
    do_reset();
    add(0,1,0,0,0,0, 1,32'h4,1,32'h4,32'h4,ST_REQ);
    add(0,0,0,0,0,0, 1,32'h4,0,32'h0,32'h4,ST_REQ);
    add(0,0,0,0,0,0, 1,32'h4,0,32'h0,32'h4,ST_REQ);
    add(0,1,0,0,0,0, 1,32'h8,1,32'h8,32'h8,ST_REQ);
    run_table("wait");

    // redirects: drain after branch, jmp priority, flush in HOLD, retarget in DRAIN
    do_reset();
    add(0,1,0,0,0,0, 1,32'h4,1,32'h4,32'h4,ST_REQ);
    add(0,1,0,0,0,0, 1,32'h8,1,32'h8,32'h8,ST_REQ);
    add(0,1,0,0,0,0, 1,32'hC,1,32'hC,32'hC,ST_REQ);
    add(0,1,0,0,0,0, 1,32'h10,1,32'h10,32'h10,ST_REQ);
    add(0,0,1,32'h103,0,0, 1,32'h10,0,32'h0,32'h100,ST_DRAIN);
    add(0,0,0,0,0,0, 1,32'h10,0,32'h0,32'h100,ST_DRAIN);
    add(0,1,0,0,0,0, 1,32'h100,0,32'h0,32'h100,ST_REQ);
    add(0,1,0,0,0,0, 1,32'h104,1,32'h104,32'h104,ST_REQ);
    add(0,1,1,32'h300,1,32'h200, 1,32'h200,0,32'h0,32'h200,ST_REQ);
    add(0,1,0,0,0,0, 1,32'h204,1,32'h204,32'h204,ST_REQ);
    add(1,1,0,0,0,0, 0,32'h204,1,32'h204,32'h208,ST_HOLD);
    add(1,0,0,0,1,32'h41, 1,32'h40,0,32'h0,32'h40,ST_REQ);
    add(0,1,0,0,0,0, 1,32'h44,1,32'h44,32'h44,ST_REQ);
    add(0,0,1,32'h80,0,0, 1,32'h44,0,32'h0,32'h80,ST_DRAIN);
    add(1,0,0,0,1,32'hC0, 1,32'h44,0,32'h0,32'hC0,ST_DRAIN);
    add(0,1,1,32'h1000,0,0, 1,32'h1000,0,32'h0,32'h1000,ST_REQ);
    add(0,1,0,0,0,0, 1,32'h1004,1,32'h1004,32'h1004,ST_REQ);
    run_table("redir");

    // reset arriving while a request is waiting, then restart at RESET_PC
    do_reset();
    add(0,1,0,0,0,0, 1,32'h4,1,32'h4,32'h4,ST_REQ);
    add(0,0,0,0,0,0, 1,32'h4,0,32'h0,32'h4,ST_REQ);
    run_table("midwait");
    do_reset();
    add(0,1,0,0,0,0, 1,32'h4,1,32'h4,32'h4,ST_REQ);
    run_table("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
